cache_const_mul_pipe: RTL and testbench

Parametrised pipelined constant multiplier: out_data = in_data * MUL_CONST, with configurable pipeline depth, width and overflow handling. Uses a valid/ready elastic handshake with per-stage bubble collapsing. Successor to the fixed x10, single-retime-stage multipliers in the cache datapath. Used for address/index scaling between cache pipeline stages that may stall.

---
 rtl/cache_const_mul_pipe.sv | 99 +++++++++
 tb/tb_cache_const_mul_pipe.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_const_mul_pipe.sv
// Elastic pipelined constant multiplier: out_data = in_data * MUL_CONST.
// Ports: clk/rst, in_vld/in_rdy/in_data, out_vld/out_rdy/out_data/out_ovf, busy.
module cache_const_mul_pipe #(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 20,
  parameter int MUL_CONST = 10,
  parameter int STAGES    = 2,
  parameter int SAT       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  localparam int PW = IN_W + 16;
  localparam int XW = (OUT_W > PW) ? OUT_W : PW;

  logic [XW-1:0]    prod;
  logic             p_ovf;
  logic [OUT_W-1:0] p_data;

  assign prod   = XW'(in_data) * XW'(MUL_CONST);
  assign p_ovf  = |(prod >> OUT_W);
  assign p_data = ((SAT != 0) && p_ovf) ? '1 : prod[OUT_W-1:0];

  logic [STAGES-1:0] v_q, v_d;
  logic [OUT_W-1:0]  data_q [STAGES];
  logic [OUT_W-1:0]  data_d [STAGES];
  logic [STAGES-1:0] ovf_q, ovf_d;

  // acc[k]: stage k can load this cycle; acc[STAGES] is the sink.
  logic [STAGES:0]   acc;
  logic [STAGES-1:0] adv;

  // A stage accepts if the sink is ready or any stage from k
  // to the output end holds a bubble (bubbles collapse).
  always_comb begin
    logic tail;
    acc         = '0;
    acc[STAGES] = out_rdy;
    tail        = 1'b1;
    for (int k = STAGES - 1; k >= 0; k--) begin
      tail   = tail & v_q[k];
      acc[k] = out_rdy | ~tail;
    end
  end

  assign adv = v_q & acc[STAGES:1];

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    ovf_d  = ovf_q;
    if (acc[0]) begin
      v_d[0] = in_vld;
      if (in_vld) begin
        data_d[0] = p_data;
        ovf_d[0]  = p_ovf;
      end
    end
    for (int k = 1; k < STAGES; k++) begin
      if (acc[k]) begin
        v_d[k] = adv[k-1];
        if (adv[k-1]) begin
          data_d[k] = data_q[k-1];
          ovf_d[k]  = ovf_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      ovf_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      v_q    <= v_d;
      ovf_q  <= ovf_d;
      data_q <= data_d;
    end
  end

  assign in_rdy   = acc[0];
  assign out_vld  = v_q[STAGES-1];
  assign out_data = data_q[STAGES-1];
  assign out_ovf  = ovf_q[STAGES-1];
  assign busy     = |v_q;

endmodule

// File: tb/tb_cache_const_mul_pipe.sv
// Bench for cache_const_mul_pipe: directed tables, stall/reset
// sequences and a randomized scoreboard run on a 4-stage instance.
module tb_cache_const_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // group A: defaults
  logic a_vld, a_rdy, a_ordy, a_ovld, a_ovf, a_busy;
  logic [15:0] a_din;
  logic [19:0] a_dout;

  // group B: OUT_W=16, sat (s_) and wrap (w_) share inputs
  logic b_vld, b_ordy;
  logic [15:0] b_din;
  logic s_rdy, s_ovld, s_ovf, s_busy;
  logic w_rdy, w_ovld, w_ovf, w_busy;
  logic [15:0] s_dout, w_dout;

  // group C: STAGES=4, MUL_CONST=3, OUT_W=17, sat
  logic c_vld, c_rdy, c_ordy, c_ovld, c_ovf, c_busy;
  logic [15:0] c_din;
  logic [16:0] c_dout;

  cache_const_mul_pipe dut_a (
    .clk(clk), .rst(rst),
    .in_vld(a_vld), .in_rdy(a_rdy), .in_data(a_din),
    .out_vld(a_ovld), .out_rdy(a_ordy), .out_data(a_dout),
    .out_ovf(a_ovf), .busy(a_busy)
  );

  cache_const_mul_pipe #(.OUT_W(16), .SAT(1)) dut_s (
    .clk(clk), .rst(rst),
    .in_vld(b_vld), .in_rdy(s_rdy), .in_data(b_din),
    .out_vld(s_ovld), .out_rdy(b_ordy), .out_data(s_dout),
    .out_ovf(s_ovf), .busy(s_busy)
  );

  cache_const_mul_pipe #(.OUT_W(16), .SAT(0)) dut_w (
    .clk(clk), .rst(rst),
    .in_vld(b_vld), .in_rdy(w_rdy), .in_data(b_din),
    .out_vld(w_ovld), .out_rdy(b_ordy), .out_data(w_dout),
    .out_ovf(w_ovf), .busy(w_busy)
  );

  cache_const_mul_pipe #(
    .OUT_W(17), .MUL_CONST(3), .STAGES(4), .SAT(1)
  ) dut_c (
    .clk(clk), .rst(rst),
    .in_vld(c_vld), .in_rdy(c_rdy), .in_data(c_din),
    .out_vld(c_ovld), .out_rdy(c_ordy), .out_data(c_dout),
    .out_ovf(c_ovf), .busy(c_busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] din;
    logic [19:0] exp;
    logic        ovf;
  } vec_a_t;

  typedef struct {
    logic [15:0] din;
    logic [15:0] sat;
    logic [15:0] wrap;
    logic        ovf;
  } vec_b_t;

  typedef struct {
    logic [16:0] d;
    logic        o;
  } res_t;

  vec_a_t ta[5];
  vec_b_t tb[5];
  res_t   sb[$];

  function automatic res_t model_c(input logic [15:0] din);
    res_t r;
    longint full;
    full = longint'(din) * 3;
    r.o  = (full > 131071);
    r.d  = r.o ? 17'h1FFFF : 17'(full);
    return r;
  endfunction

  // expected per-cycle values for the stall sequence
  int s3_rdy [11] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1};
  int s3_vld [11] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int s3_dat [11] = '{0, 0, 10, 10, 10, 10, 10, 20, 30, 40, 0};
  int s3_bsy [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};

  initial begin
    int nxt;
    int cnt;
    res_t r;
    logic hs_in, hs_out;

    ta[0] = '{16'd1234,  20'd12340,  1'b0};
    ta[1] = '{16'd65535, 20'd655350, 1'b0};
    ta[2] = '{16'd0,     20'd0,      1'b0};
    ta[3] = '{16'd1,     20'd10,     1'b0};
    ta[4] = '{16'd100,   20'd1000,   1'b0};

    tb[0] = '{16'd7000,  16'hFFFF, 16'd4464,  1'b1};
    tb[1] = '{16'd6553,  16'd65530, 16'd65530, 1'b0};
    tb[2] = '{16'd6554,  16'hFFFF, 16'd4,     1'b1};
    tb[3] = '{16'd0,     16'd0,    16'd0,     1'b0};
    tb[4] = '{16'd65535, 16'hFFFF, 16'd65526, 1'b1};

    rst = 1'b1;
    a_vld = 0; a_din = 0; a_ordy = 1;
    b_vld = 0; b_din = 0; b_ordy = 1;
    c_vld = 0; c_din = 0; c_ordy = 1;

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_in_rdy_during", 32'(a_rdy), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_out_vld", 32'(a_ovld), 32'd0);
    chk("rst_out_data", 32'(a_dout), 32'd0);
    chk("rst_out_ovf", 32'(a_ovf), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_in_rdy", 32'(a_rdy), 32'd1);
    chk("rst_c_busy", 32'(c_busy), 32'd0);

    // single operands, latency 2
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a_vld = 1; a_din = ta[i].din;
      #1 chk("a_in_rdy", 32'(a_rdy), 32'd1);
      @(negedge clk);
      a_vld = 0; a_din = 16'hDEAD;
      #1 chk("a_early_vld", 32'(a_ovld), 32'd0);
      @(negedge clk);
      #1;
      chk("a_vld", 32'(a_ovld), 32'd1);
      chk("a_data", 32'(a_dout), 32'(ta[i].exp));
      chk("a_ovf", 32'(a_ovf), 32'(ta[i].ovf));
    end

    // overflow: saturate vs wrap
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b_vld = 1; b_din = tb[i].din;
      #1 chk("b_in_rdy", 32'(s_rdy & w_rdy), 32'd1);
      @(negedge clk);
      b_vld = 0;
      #1 chk("b_early_vld", 32'(s_ovld | w_ovld), 32'd0);
      @(negedge clk);
      #1;
      chk("b_vld", 32'(s_ovld & w_ovld), 32'd1);
      chk("s_data", 32'(s_dout), 32'(tb[i].sat));
      chk("s_ovf", 32'(s_ovf), 32'(tb[i].ovf));
      chk("w_data", 32'(w_dout), 32'(tb[i].wrap));
      chk("w_ovf", 32'(w_ovf), 32'(tb[i].ovf));
    end

    // back-to-back stream 1..8
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      a_vld = (cyc < 8);
      a_din = 16'(cyc + 1);
      #1;
      chk("str_in_rdy", 32'(a_rdy), 32'd1);
      chk("str_vld", 32'(a_ovld), 32'(cyc >= 2));
      if (cyc >= 2)
        chk("str_data", 32'(a_dout), 32'((cyc - 1) * 10));
    end

    // stall with out_rdy=0 for 6 cycles, then drain
    nxt = 1;
    for (int cyc = 0; cyc < 11; cyc++) begin
      @(negedge clk);
      a_ordy = (cyc >= 6);
      a_vld  = (nxt <= 4);
      a_din  = 16'(nxt);
      #1;
      chk("stl_in_rdy", 32'(a_rdy), 32'(s3_rdy[cyc]));
      chk("stl_vld", 32'(a_ovld), 32'(s3_vld[cyc]));
      if (s3_vld[cyc] != 0)
        chk("stl_data", 32'(a_dout), 32'(s3_dat[cyc]));
      chk("stl_busy", 32'(a_busy), 32'(s3_bsy[cyc]));
      if (a_vld && a_rdy) nxt++;
    end
    a_vld = 0;

    // reset with two entries in flight
    @(negedge clk);
    a_ordy = 0; a_vld = 1; a_din = 16'd1;
    @(negedge clk);
    a_din = 16'd2;
    @(negedge clk);
    #1 chk("mid_busy_pre", 32'(a_busy), 32'd1);
    rst = 1; a_din = 16'd3;
    @(negedge clk);
    rst = 0; a_vld = 0; a_ordy = 1;
    #1;
    chk("mid_vld", 32'(a_ovld), 32'd0);
    chk("mid_data", 32'(a_dout), 32'd0);
    chk("mid_busy", 32'(a_busy), 32'd0);
    chk("mid_in_rdy", 32'(a_rdy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 chk("mid_stale", 32'(a_ovld), 32'd0);
    end

    // 4-stage latency, unstalled
    @(negedge clk);
    c_vld = 1; c_din = 16'd5; c_ordy = 1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      c_vld = 0;
      #1 chk("c_lat_vld", 32'(c_ovld), 32'(i == 4));
    end
    chk("c_lat_data", 32'(c_dout), 32'd15);

    // randomized scoreboard
    @(negedge clk);
    cnt = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      c_ordy = 1'($urandom_range(0, 1));
      c_vld  = ($urandom_range(0, 3) != 0);
      c_din  = 16'($urandom);
      #1;
      chk("rnd_in_rdy", 32'(c_rdy), 32'((cnt < 4) || c_ordy));
      chk("rnd_busy", 32'(c_busy), 32'(cnt != 0));
      if (cnt == 0) chk("rnd_idle_vld", 32'(c_ovld), 32'd0);
      hs_out = c_ovld & c_ordy;
      hs_in  = c_vld & c_rdy;
      if (hs_out) begin
        if (sb.size() == 0) begin
          chk("rnd_spurious", 32'd1, 32'd0);
        end else begin
          r = sb.pop_front();
          chk("rnd_data", 32'(c_dout), 32'(r.d));
          chk("rnd_ovf", 32'(c_ovf), 32'(r.o));
          cnt--;
        end
      end
      if (hs_in) begin
        sb.push_back(model_c(c_din));
        cnt++;
      end
    end

    // drain with a bounded wait
    c_vld = 0;
    for (int cyc = 0; cyc < 20 && sb.size() != 0; cyc++) begin
      @(negedge clk);
      c_ordy = 1;
      #1;
      if (c_ovld) begin
        r = sb.pop_front();
        chk("drn_data", 32'(c_dout), 32'(r.d));
        chk("drn_ovf", 32'(c_ovf), 32'(r.o));
      end
    end
    chk("drn_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);
    #1 chk("drn_busy", 32'(c_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
